// File: rtl/bootrom_arbiter_if.sv
// bootrom_arbiter_if: request/grant/response bundle between bus masters
// and the boot ROM arbiter, one lane per master port.
interface bootrom_arbiter_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS-1:0]    req;
    logic [N_PORTS*32-1:0] addr;
    logic [N_PORTS-1:0]    gnt;
    logic [N_PORTS-1:0]    rvalid;
    logic [31:0]           rdata;
    logic                  rerr;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, rerr
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, rerr
    );
endinterface

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: round-robin N-port read front end for a single-port boot ROM.
// Validates byte addresses and routes each word back through a tag pipeline.
module bootrom_arbiter #(
    parameter int          N_PORTS     = 2,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1FC0_0000,
    parameter int          ROM_LATENCY = 1,
    parameter int          ROM_AW      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    bootrom_arbiter_if.slave  bus,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data
);
    localparam int          IW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
    localparam int          LAST = ROM_LATENCY - 1;

    logic [IW-1:0]                  r_last;
    logic [ROM_AW-1:0]              r_addr;
    logic [ROM_LATENCY-1:0]         r_v;
    logic [ROM_LATENCY-1:0]         r_e;
    logic [ROM_LATENCY-1:0][IW-1:0] r_p;

    logic          w_any;
    logic          w_go;
    logic          w_err;
    logic          w_en;
    logic [IW-1:0] w_idx;
    logic [31:0]   w_a;
    logic [31:0]   w_off;

    // Ports above r_last win first, then the scan wraps to port 0.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_a   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!w_any && bus.req[i] && (IW'(i) > r_last)) begin
                w_any = 1'b1;
                w_idx = IW'(i);
                w_a   = bus.addr[32*i +: 32];
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (!w_any && bus.req[i] && (IW'(i) <= r_last)) begin
                w_any = 1'b1;
                w_idx = IW'(i);
                w_a   = bus.addr[32*i +: 32];
            end
        end
    end

    // Wrapping subtract folds below-base addresses into the out-of-range case.
    assign w_go     = w_any & rst;
    assign w_off    = w_a - BASE_ADDR;
    assign w_err    = (w_a[1:0] != 2'b00) || (w_off >= SPAN);
    assign w_en     = w_go & ~w_err;
    assign rom_en   = w_en;
    assign rom_addr = w_en ? w_off[ROM_AW+1:2] : r_addr;

    always_comb begin
        bus.gnt = '0;
        if (w_go) begin
            bus.gnt[w_idx] = 1'b1;
        end
    end

    always_comb begin
        bus.rvalid = '0;
        if (r_v[LAST]) begin
            bus.rvalid[r_p[LAST]] = 1'b1;
        end
    end

    assign bus.rdata = (r_v[LAST] && !r_e[LAST]) ? rom_data : 32'h0;
    assign bus.rerr  = r_v[LAST] & r_e[LAST];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= IW'(N_PORTS - 1);
            r_addr <= '0;
            r_v    <= '0;
            r_e    <= '0;
            r_p    <= '0;
        end else begin
            if (w_go) begin
                r_last <= w_idx;
            end
            if (w_en) begin
                r_addr <= rom_addr;
            end
            r_v[0] <= w_go;
            r_p[0] <= w_idx;
            r_e[0] <= w_err;
            for (int s = 1; s < ROM_LATENCY; s++) begin
                r_v[s] <= r_v[s-1];
                r_p[s] <= r_p[s-1];
                r_e[s] <= r_e[s-1];
            end
        end
    end
endmodule

// File: doc/bootrom_arbiter.md
# bootrom_arbiter

Multi-port read controller for the boot ROM. It lets N independent bus masters (IF, EX, debug/DMA, ...) share one single-port synchronous ROM macro, replacing the fixed two-port hard-wired scheme. The block provides:
- per-port request/grant handshake with round-robin arbitration;
- byte-address decode against a configurable base and size, with error responses for misaligned or out-of-range addresses;
- a tag pipeline that routes each ROM word back to its requester after a parametrised macro latency.

It sits between the bus interconnect and the ROM macro.

## Interface
- N_PORTS, 2, number of requesting masters (1..8)
- DEPTH_WORDS, 4096, ROM depth in 32-bit words (power of two)
- BASE_ADDR, 32'h1FC0_0000, byte address of ROM word 0
- ROM_LATENCY, 1, macro read latency in cycles (1..3)
- ROM_AW, $clog2(DEPTH_WORDS), ROM word-address width (derived)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_PORTS  per-port read request, held until granted
- addr  in  N_PORTS*32  per-port byte address, port i at [32i+31:32i]
- gnt  out  N_PORTS  one-hot grant, combinational from req
- rvalid  out  N_PORTS  one-hot response strobe, one cycle
- rdata  out  32  response word, shared by all ports, qualified by rvalid
- rerr  out  1  response error flag, qualified by rvalid
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM word address
- rom_data  in  32  ROM read data, valid ROM_LATENCY cycles after rom_en

## Operation
- **Arbitration**
  - Round-robin over requesting ports.
  - The port after last_grant has highest priority, wrapping N_PORTS-1 to 0.
  - At most one gnt bit per cycle; gnt is all-zero when req is all-zero.
  - last_grant updates on every grant.
  - Reset value of last_grant is N_PORTS-1, so port 0 has highest priority after reset.
- **Address decode** for the granted address A:
  - off = A - BASE_ADDR, computed in 32-bit unsigned arithmetic with wrap.
  - Access is in range iff off < DEPTH_WORDS*4.
  - Access is misaligned iff A[1:0] != 0.
  - err = misaligned OR out-of-range.
- **ROM issue**
  - rom_en = grant_any AND NOT err.
  - rom_addr = off[ROM_AW+1:2].
  - When rom_en=0, rom_addr holds its previous value (registered shadow); reset value 0.
- **Tag pipeline**
  - ROM_LATENCY stages; each stage holds {valid, port index, err}.
  - Stage 0 loads {grant_any, granted index, err} every cycle.
- **Response**
  - When the last tag stage has valid=1, rvalid[port]=1.
  - rdata = err ? 32'h0 : rom_data; rerr = err.
  - Otherwise rvalid=0, rdata=0, rerr=0.
  - Error requests consume a grant slot and return with the same latency as good ones, so ordering is strictly preserved.
- Each grant produces exactly one response. Responses come back in grant order.
- Throughput is one request per cycle. No backpressure exists on responses: masters must accept rvalid unconditionally.
- **Reset**
  - Assertion clears all tag stages and last_grant asynchronously.
  - In-flight responses are dropped and never delivered.
  - gnt, rvalid, rom_en, rerr and rdata are 0 while rst=0.

## Timing
- Cycle t: req[i]=1 and port i wins → gnt[i]=1, rom_en/rom_addr valid in cycle t.
- Cycle t+ROM_LATENCY: rvalid[i]=1 and rdata valid. The rom_data to rdata path is combinational (mux only).
- A master may drop req or change addr in cycle t+1 after seeing gnt in cycle t.
- A master may issue back-to-back: req held high across grants yields a grant every cycle if uncontended.
- With all N_PORTS requesting continuously, each port is granted exactly once every N_PORTS cycles.
- A request raised in the same cycle that another port's response returns is unaffected; request and response paths are independent.
- The first grant is possible in the first clk edge after rst deasserts; no startup stall.

## Test plan
- **Single port, ROM_LATENCY=1:** port 0 requests 0x1FC0_0008 → gnt[0] same cycle, rom_addr=2, rvalid[0] next cycle with rdata=ROM[2], rerr=0.
- **Contention, N_PORTS=3:** all ports request continuously for 6 cycles after reset → grants 0,1,2,0,1,2. Responses follow 1:1 in the same order.
- **Errors:**
  - Port 1 requests 0x1FC0_0002 → rom_en=0, rvalid[1] after ROM_LATENCY with rerr=1, rdata=0.
  - Port 1 requests 0x1FC0_0000+DEPTH_WORDS*4 → same error response.
  - Port 1 requests 0x0000_0000 → same error response (wrap makes off huge).
- **ROM_LATENCY=3 pipelining:** alternating good/error requests from ports 0 and 1 every cycle for 8 cycles → 8 responses, each exactly 3 cycles after its grant, correct port, data and rerr.
- **Reset mid-flight, ROM_LATENCY=3:** assert rst one cycle after two grants → no rvalid ever appears for them. After deassert, port 0 regains first priority.
- **Boundary:** request to the last word (offset DEPTH_WORDS*4-4) → rom_addr=DEPTH_WORDS-1, rerr=0.
